// File: rtl/spectrum_peak_finder.sv
// Captures one FFT output frame, scans bins 0..NFFT/2-1 one per cycle and
// reports the strongest bin of each equal-width band over a valid/ready handshake.
module spectrum_peak_finder #(
  parameter int NFFT       = 512,
  parameter int DATA_WIDTH = 32,
  parameter int BANDS      = 4,
  parameter int EXCLUDE_DC = 1,
  localparam int HALF      = NFFT / 2,
  localparam int BW        = HALF / BANDS,
  localparam int IDX_W     = $clog2(HALF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] spec_in [NFFT],
  input  logic                  spec_valid,
  output logic                  busy,
  output logic [IDX_W-1:0]      peak_idx [BANDS],
  output logic [DATA_WIDTH-1:0] peak_mag [BANDS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            drop_count
);

  localparam int BW_LOG = $clog2(BW);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS  = ~MOST_NEG;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] frame [HALF];
  logic [IDX_W-1:0]      c;
  logic [IDX_W-1:0]      band;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] mag;
  logic                  capture;
  logic                  drop;
  logic [DATA_WIDTH-1:0] unused_upper;

  // Bins above Nyquist are redundant for a real input and never read.
  always_comb begin
    unused_upper = '0;
    for (int unsigned i = HALF; i < NFFT; i++) unused_upper ^= spec_in[i];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (spec_valid) begin
          capture    = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        drop = spec_valid;
        if (c == IDX_W'(HALF - 1)) next_state = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          next_state = IDLE;
          if (spec_valid) begin
            capture    = 1'b1;
            next_state = SCAN;
          end
        end else begin
          drop = spec_valid;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  // Absolute value saturates the most negative code to the largest positive one.
  always_comb begin
    sample = frame[c];
    if (sample == MOST_NEG)          mag = MAX_POS;
    else if (sample[DATA_WIDTH-1])   mag = -sample;
    else                             mag = sample;
    if (EXCLUDE_DC != 0 && c == '0)  mag = '0;
    band = c >> BW_LOG;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < HALF; i++) frame[i] <= spec_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c          <= '0;
      drop_count <= '0;
      for (int unsigned b = 0; b < BANDS; b++) begin
        peak_idx[b] <= '0;
        peak_mag[b] <= '0;
      end
    end else begin
      if (capture) begin
        c <= '0;
        for (int unsigned b = 0; b < BANDS; b++) begin
          peak_idx[b] <= IDX_W'(b * BW);
          peak_mag[b] <= '0;
        end
      end else if (state == SCAN) begin
        c <= c + 1'b1;
        // Strict compare keeps the earliest bin on ties.
        for (int unsigned b = 0; b < BANDS; b++) begin
          if (band == IDX_W'(b) && mag > peak_mag[b]) begin
            peak_idx[b] <= c;
            peak_mag[b] <= mag;
          end
        end
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed and randomized checks of spectrum_peak_finder (NFFT=32, BANDS=4)
// against a per-band maximum model computed with plain integer arithmetic.
module tb_spectrum_peak_finder;

  localparam int NFFT = 32;
  localparam int HALF = 16;
  localparam int NB   = 4;
  localparam int BW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] spec_in [NFFT];
  logic        spec_valid;
  logic        busy;
  logic [3:0]  peak_idx [NB];
  logic [31:0] peak_mag [NB];
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;
  int lat;

  logic [31:0] frame_v [NFFT];
  logic [3:0]  want_idx [NB];
  logic [31:0] want_mag [NB];

  spectrum_peak_finder #(
    .NFFT(NFFT), .DATA_WIDTH(32), .BANDS(NB), .EXCLUDE_DC(1)
  ) dut (
    .clk(clk), .reset(reset), .spec_in(spec_in), .spec_valid(spec_valid),
    .busy(busy), .peak_idx(peak_idx), .peak_mag(peak_mag),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Per band: largest saturated magnitude, earliest bin on ties, bin 0 forced to 0.
  task automatic model();
    longint v, m;
    for (int b = 0; b < NB; b++) begin
      want_idx[b] = 4'(b * BW);
      want_mag[b] = 32'd0;
      for (int i = b * BW; i < (b + 1) * BW; i++) begin
        v = longint'(signed'(frame_v[i]));
        m = (v < 0) ? -v : v;
        if (m > 64'sh7FFF_FFFF) m = 64'sh7FFF_FFFF;
        if (i == 0) m = 0;
        if (m > longint'(want_mag[b])) begin
          want_mag[b] = 32'(m);
          want_idx[b] = 4'(i);
        end
      end
    end
  endtask

  task automatic check_peaks(input string tag);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_idx%0d", tag, b), 64'(peak_idx[b]), 64'(want_idx[b]));
      chk($sformatf("%s_mag%0d", tag, b), 64'(peak_mag[b]), 64'(want_mag[b]));
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NFFT; i++) frame_v[i] = 32'd0;
  endtask

  task automatic random_frame();
    for (int i = 0; i < NFFT; i++) begin
      case ($urandom_range(0, 3))
        0:       frame_v[i] = $urandom;
        1:       frame_v[i] = 32'($signed($urandom_range(0, 14)) - 7);
        2:       frame_v[i] = 32'h8000_0000;
        default: frame_v[i] = 32'($urandom_range(0, 5000));
      endcase
    end
  endtask

  // Drive frame_v for one cycle with spec_valid and refresh the model.
  task automatic send_frame();
    for (int i = 0; i < NFFT; i++) spec_in[i] = frame_v[i];
    spec_valid = 1'b1;
    tick();
    spec_valid = 1'b0;
    for (int i = 0; i < NFFT; i++) spec_in[i] = $urandom;
    model();
  endtask

  // Called in cycle T+1; returns k such that out_valid rose at T+k.
  task automatic wait_result(output int k);
    k = 1;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    spec_valid = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < NFFT; i++) spec_in[i] = '0;

    // Reset
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    for (int b = 0; b < NB; b++) begin
      chk("rst_idx", 64'(peak_idx[b]), 64'd0);
      chk("rst_mag", 64'(peak_mag[b]), 64'd0);
    end

    // Single peak with DC excluded
    clear_frame();
    frame_v[0] = 32'd5000;
    frame_v[5] = -32'd1000;
    send_frame();
    chk("sp_busy", 64'(busy), 64'd1);
    for (int k = 2; k <= 16; k++) tick();
    chk("sp_early", 64'(out_valid), 64'd0);
    tick();
    chk("sp_valid", 64'(out_valid), 64'd1);
    chk("sp_i0", 64'(peak_idx[0]), 64'd0);
    chk("sp_i1", 64'(peak_idx[1]), 64'd5);
    chk("sp_i2", 64'(peak_idx[2]), 64'd8);
    chk("sp_i3", 64'(peak_idx[3]), 64'd12);
    chk("sp_m0", 64'(peak_mag[0]), 64'd0);
    chk("sp_m1", 64'(peak_mag[1]), 64'd1000);
    chk("sp_m2", 64'(peak_mag[2]), 64'd0);
    chk("sp_m3", 64'(peak_mag[3]), 64'd0);
    tick();
    chk("sp_fall", 64'(out_valid), 64'd0);
    chk("sp_idle", 64'(busy), 64'd0);

    // Tie and saturation
    clear_frame();
    frame_v[9]  = 32'd300;
    frame_v[10] = 32'd300;
    frame_v[13] = 32'h8000_0000;
    send_frame();
    wait_result(lat);
    chk("ts_lat", 64'(lat), 64'd17);
    chk("ts_i2", 64'(peak_idx[2]), 64'd9);
    chk("ts_m2", 64'(peak_mag[2]), 64'd300);
    chk("ts_i3", 64'(peak_idx[3]), 64'd13);
    chk("ts_m3", 64'(peak_mag[3]), 64'h7FFF_FFFF);
    tick();

    // Backpressure, drop in HOLD, accept together with a new frame
    out_ready = 1'b0;
    random_frame();
    send_frame();
    wait_result(lat);
    chk("bp_lat", 64'(lat), 64'd17);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) spec_valid = 1'b1;
      tick();
      spec_valid = 1'b0;
      chk("bp_hold", 64'(out_valid), 64'd1);
      check_peaks("bp");
    end
    chk("bp_drop", 64'(drop_count), 64'd1);
    out_ready = 1'b1;
    random_frame();
    send_frame();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_vlow", 64'(out_valid), 64'd0);
    wait_result(lat);
    chk("bp_lat2", 64'(lat), 64'd17);
    check_peaks("bp2");
    chk("bp_drop2", 64'(drop_count), 64'd1);
    tick();

    // Reset in the middle of a scan
    random_frame();
    send_frame();
    for (int k = 2; k <= 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_drop", 64'(drop_count), 64'd0);
    chk("rm_mag1", 64'(peak_mag[1]), 64'd0);
    lat = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("rm_novalid", 64'(lat), 64'd0);
    random_frame();
    send_frame();
    wait_result(lat);
    chk("rm_lat", 64'(lat), 64'd17);
    check_peaks("rm");
    tick();

    // Randomized frames with back-to-back acceptance
    for (int n = 0; n < 6; n++) begin
      random_frame();
      send_frame();
      wait_result(lat);
      chk("rnd_lat", 64'(lat), 64'd17);
      check_peaks("rnd");
      tick();
    end

    // Drop counter saturation while held in HOLD
    out_ready = 1'b0;
    random_frame();
    send_frame();
    wait_result(lat);
    chk("ds_lat", 64'(lat), 64'd17);
    for (int k = 0; k < 300; k++) begin
      spec_valid = 1'b1;
      tick();
      spec_valid = 1'b0;
      tick();
    end
    chk("ds_sat", 64'(drop_count), 64'd255);
    chk("ds_hold", 64'(out_valid), 64'd1);
    check_peaks("ds");
    out_ready = 1'b1;
    tick();
    chk("ds_done", 64'(out_valid), 64'd0);
    chk("ds_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
